// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and the receive paths.
// Keeping state encodings and baud/frame constants here keeps both ends
// of the link consistent.
package uart_pkg;

  // Line-state encoding shared by TX and RX.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // 50 MHz system clock / 9600 baud.
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 5208;

  localparam int unsigned BITS_PER_BYTE   = 8;
  localparam int unsigned BYTES_PER_FRAME = 2;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Held at zero while clear is high, so the first bit
// after a clear lasts exactly CLKS_PER_BIT cycles. The receiver can use
// the same block for mid-bit sampling.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = (cnt_q == LAST);

  // Next count: restart on clear or at the terminal count, never wrap past it.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame2.sv
// Two-byte UART transmitter (8N1): sends primeiroByte then segundoByte
// back-to-back, LSB first, with no idle gap between the two bytes.
// Defining UART_TX_FRAME2_PARITY_EN adds an even-parity bit per byte (8E1).
// All outputs are registered.
module uart_tx_frame2
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       haDadosParaTransmitir,
  input  logic [7:0] primeiroByte,
  input  logic [7:0] segundoByte,
  output logic       indicaTransmissao,
  output logic       bitSerialAtualTX,
  output logic       bitsEstaoEnviados
);

  localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);
  localparam logic       LAST_BYTE = 1'(BYTES_PER_FRAME - 1);

  uart_state_e state_q, state_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        byte_idx_q, byte_idx_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        timer_clear;
  logic        bit_end;
  logic [7:0]  cur_byte;
  logic [2:0]  next_bit;

  assign cur_byte = byte_idx_q ? byte1_q : byte0_q;
  assign next_bit = bit_idx_q + 3'd1;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .bit_end (bit_end)
  );

  // Next-state and next-output logic; the line value for the upcoming
  // bit is computed together with the transition so tx stays registered.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timer_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        timer_clear = 1'b1;
        if (haDadosParaTransmitir) begin
          byte0_d    = primeiroByte;
          byte1_d    = segundoByte;
          byte_idx_d = 1'b0;
          state_d    = ST_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_FRAME2_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = even_parity(cur_byte);
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = next_bit;
            tx_d      = cur_byte[next_bit];
          end
        end
      end

`ifdef UART_TX_FRAME2_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = ST_START;
            tx_d       = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 1'b0;
      byte0_q    <= 8'h00;
      byte1_q    <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      byte0_q    <= byte0_d;
      byte1_q    <= byte1_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bitSerialAtualTX  = tx_q;
  assign indicaTransmissao = busy_q;
  assign bitsEstaoEnviados = done_q;

endmodule

// File: doc/uart_tx_frame2.md
Name: uart_tx_frame2

Overview:
- UART 8N1 transmitter returning a two-byte frame from the FPGA to the PC.
- Counterpart of the existing two-byte receive path: the receiver takes a command/address byte pair from the PC; this block sends a response pair (status/command echo byte, then DHT11 data byte) over the same serial link.
- Sits between the DHT11 processing logic (frame source) and the TX pin; drives the TX-activity and TX-done indicator outputs.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- haDadosParaTransmitir  input  1  request; sampled only in IDLE.
- primeiroByte  input  8  first byte sent; latched on request acceptance.
- segundoByte  input  8  second byte sent; latched on request acceptance.
- indicaTransmissao  output  1  busy; high from acceptance until the end of the last stop bit.
- bitSerialAtualTX  output  1  serial line; idle high.
- bitsEstaoEnviados  output  1  one-cycle pulse when the full frame is done.

Behaviour:
- Clock and reset: single clock `clock`; reset `reset` is synchronous and active-high.
- Reset values: state=IDLE, bitSerialAtualTX=1, indicaTransmissao=0, bitsEstaoEnviados=0, bit counter=0, byte index=0, cycle counter=0.
- All outputs are registered; no combinational path from input to output.
- States: IDLE, START, DATA, STOP (plus PARITY when the option is enabled).
- IDLE:
  - tx=1, busy=0.
  - If request=1 at edge k: latch both bytes, byte index=0, go to START.
  - After edge k: tx=0 and busy=1.
- Bit timing:
  - Every state except IDLE holds its line value for exactly CLKS_PER_BIT cycles.
  - The cycle counter runs 0..CLKS_PER_BIT-1, then the state advances.
- START: tx=0, then go to DATA with bit index=0.
- DATA:
  - tx = current byte[bit index], LSB first.
  - After bit 7, go to STOP (or PARITY).
- STOP: tx=1, for one bit period.
  - Byte index 0: go to START for byte 1, with no idle gap.
  - Byte index 1: go to IDLE; busy=0 and done=1 on that same edge.
- Done pulse: high exactly one cycle. The IDLE cycle in which done=1 may itself accept a new request.
- Frame length: 20*CLKS_PER_BIT cycles from acceptance edge to the edge raising done (22*CLKS_PER_BIT with parity).
- Request handling:
  - Request while busy is ignored, not queued.
  - Byte inputs changing mid-frame have no effect.
  - Request held high continuously causes back-to-back frames separated by exactly one IDLE cycle.
- Reset mid-frame: on the next edge tx=1, busy=0, no done pulse, frame abandoned.
- Reset and request in the same cycle: reset wins, request not accepted.
- CLKS_PER_BIT counter width: $clog2(CLKS_PER_BIT); no wrap-around beyond the terminal count.

Optional Feature:
- Macro: UART_TX_FRAME2_PARITY_EN.
- Defined:
  - After DATA, a PARITY state drives the even-parity bit (XOR of the 8 data bits) for one bit period, then STOP.
  - Frame becomes 8E1 per byte.
  - The receiver must be built with matching parity.
- Undefined: PARITY state and logic absent; 8N1 only.

Decomposition:
- Shared package/header uart_pkg, holding:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - default baud constant UART_CLKS_PER_BIT_DEFAULT=5208;
  - frame constants BITS_PER_BYTE=8, BYTES_PER_FRAME=2.
- The same package is used by the receive path so both ends agree on encoding and baud.
- One natural sub-module, uart_bit_timer:
  - cycle counter with parameter CLKS_PER_BIT;
  - inputs clock, reset, clear;
  - output bit_end pulse.
  - Reusable by the receiver for mid-bit sampling.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Single frame: request one cycle with primeiroByte=0x55, segundoByte=0xA3.
  - tx sequence per 4 cycles: 0,1,0,1,0,1,0,1,0,1 | 0,1,1,0,0,0,1,0,1,1.
  - busy high for 80 cycles; done pulse on cycle 80; tx=1 afterwards.
- Busy rejection: second request with 0xFF/0xFF at cycle 10 of a 0x00/0x00 frame.
  - Line carries only 0x00/0x00.
  - Exactly one done pulse; no second frame.
- Back-to-back: request held high, bytes 0x12/0x34.
  - Two identical 80-cycle frames.
  - One IDLE cycle between them.
  - Two done pulses 81 cycles apart.
- Reset mid-frame: reset asserted at cycle 30 of a 0xAA/0x55 frame.
  - Next cycle tx=1, busy=0; done never asserted.
  - A new request after reset produces a complete correct frame.
- Loopback at CLKS_PER_BIT=5208: TX output fed into the existing two-byte receiver, bytes 0x01/0x3C.
  - Receiver reports first byte 0x01, second byte 0x3C, and its done flag.
- Parity build (UART_TX_FRAME2_PARITY_EN), bytes 0x07/0x03.
  - Parity bits 1 and 0 respectively.
  - Frame length 88 cycles; done on cycle 88.
